// File: rtl/gem_cluster_pkg.sv
// Shared widths and bus types for the GEM cluster sorter scheduler.
package gem_cluster_pkg;
    localparam int ADR_W  = 11;
    localparam int CNT_W  = 3;
    localparam int NSLOTS = 8;
    localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;

    typedef logic [NSLOTS*ADR_W-1:0] adr_bus_t;
    typedef logic [NSLOTS*CNT_W-1:0] cnt_bus_t;
endpackage

// File: rtl/cluster_count8.sv
// Counts the cluster slots whose address differs from the empty-slot marker.
module cluster_count8
    import gem_cluster_pkg::*;
#(
    parameter logic [10:0] INVALID_ADR = 11'h7FF
) (
    input  logic [NSLOTS*ADR_W-1:0] adr,
    output logic [3:0]              count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (adr[i*ADR_W +: ADR_W] != INVALID_ADR)
                count = count + 4'd1;
        end
    end

endmodule

// File: rtl/cluster_sort_scheduler.sv
// Schedules the two time-multiplexed cluster sorters and holds one captured
// frame per half-frame behind a valid/ready handshake.
module cluster_sort_scheduler
    import gem_cluster_pkg::*;
#(
    parameter logic [10:0] INVALID_ADR = 11'h7FF,
    parameter int          DROP_W      = 16
) (
    input  logic                    clock4x,
    input  logic                    global_reset,
    input  logic                    bx0,
    input  logic [3:0]              cfg_delay_a,
    input  logic [3:0]              cfg_delay_b,
    input  logic [1:0]              cfg_capture_phase,
    input  logic                    err_clear,
    input  logic [NSLOTS*ADR_W-1:0] sorter_adr,
    input  logic [NSLOTS*CNT_W-1:0] sorter_cnt,
    output logic [3:0]              delay_a,
    output logic [3:0]              delay_b,
    output logic                    cycle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NSLOTS*ADR_W-1:0] out_adr,
    output logic [NSLOTS*CNT_W-1:0] out_cnt,
    output logic [3:0]              out_nclusters,
    output logic                    out_src,
    output logic                    phase_err,
    output logic [DROP_W-1:0]       drop_cnt
);

    logic [2:0] phase;
    logic [3:0] nclusters;
    logic       capture;
    logic       slot_free;
    logic       err_set;

    cluster_count8 #(.INVALID_ADR(INVALID_ADR)) u_count (
        .adr   (sorter_adr),
        .count (nclusters)
    );

    // The mux select is the phase MSB itself, so it can never glitch.
    assign cycle     = phase[2];
    assign capture   = (phase[1:0] == cfg_capture_phase);
    assign slot_free = !out_valid || out_ready;
    assign err_set   = bx0 && (phase != 3'd0);

    // NOTE: all state updates use non-blocking assignments so every register
    // sees pre-edge values; the held frame is reset too, so a reset mid-frame
    // can never leak stale cluster data downstream.
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            phase         <= 3'd1;
            delay_a       <= 4'd7;
            delay_b       <= 4'd3;
            out_valid     <= 1'b0;
            out_adr       <= {NSLOTS{INVALID_ADR}};
            out_cnt       <= '0;
            out_nclusters <= '0;
            out_src       <= 1'b0;
            phase_err     <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            phase <= bx0 ? 3'd1 : phase + 3'd1;

            if (err_set)
                phase_err <= 1'b1;
            else if (err_clear)
                phase_err <= 1'b0;

            // Sorter delays only change at the frame boundary.
            if (phase == 3'd0) begin
                delay_a <= cfg_delay_a;
                delay_b <= cfg_delay_b;
            end

            if (capture && slot_free) begin
                out_adr       <= sorter_adr;
                out_cnt       <= sorter_cnt;
                out_src       <= cycle;
                out_nclusters <= nclusters;
                out_valid     <= 1'b1;
            end else if (capture) begin
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cluster_sort_scheduler.sv
// Scoreboard bench for cluster_sort_scheduler: a behavioural model predicts
// each accepted frame and compares it when the DUT presents it.
module tb_cluster_sort_scheduler;
    import gem_cluster_pkg::*;

    logic        clock4x = 1'b0;
    logic        global_reset;
    logic        bx0;
    logic [3:0]  cfg_delay_a, cfg_delay_b;
    logic [1:0]  cfg_capture_phase;
    logic        err_clear;
    logic [87:0] sorter_adr;
    logic [23:0] sorter_cnt;
    logic        out_ready;

    logic [3:0]  delay_a, delay_b;
    logic        cycle, out_valid, out_src, phase_err;
    logic [87:0] out_adr;
    logic [23:0] out_cnt;
    logic [3:0]  out_nclusters;
    logic [15:0] drop_cnt;

    logic [3:0]  delay_a4, delay_b4, out_nclusters4, drop_cnt4;
    logic        cycle4, out_valid4, out_src4, phase_err4;
    logic [87:0] out_adr4;
    logic [23:0] out_cnt4;

    cluster_sort_scheduler dut (
        .clock4x(clock4x), .global_reset(global_reset), .bx0(bx0),
        .cfg_delay_a(cfg_delay_a), .cfg_delay_b(cfg_delay_b),
        .cfg_capture_phase(cfg_capture_phase), .err_clear(err_clear),
        .sorter_adr(sorter_adr), .sorter_cnt(sorter_cnt),
        .delay_a(delay_a), .delay_b(delay_b), .cycle(cycle),
        .out_valid(out_valid), .out_ready(out_ready), .out_adr(out_adr),
        .out_cnt(out_cnt), .out_nclusters(out_nclusters), .out_src(out_src),
        .phase_err(phase_err), .drop_cnt(drop_cnt)
    );

    cluster_sort_scheduler #(.DROP_W(4)) dut4 (
        .clock4x(clock4x), .global_reset(global_reset), .bx0(bx0),
        .cfg_delay_a(cfg_delay_a), .cfg_delay_b(cfg_delay_b),
        .cfg_capture_phase(cfg_capture_phase), .err_clear(err_clear),
        .sorter_adr(sorter_adr), .sorter_cnt(sorter_cnt),
        .delay_a(delay_a4), .delay_b(delay_b4), .cycle(cycle4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_adr(out_adr4),
        .out_cnt(out_cnt4), .out_nclusters(out_nclusters4), .out_src(out_src4),
        .phase_err(phase_err4), .drop_cnt(drop_cnt4)
    );

    always #5 clock4x = ~clock4x;

    typedef struct {
        logic [87:0] adr;
        logic [23:0] cnt;
        logic        src;
        logic [3:0]  ncl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  m_phase;
    logic        m_valid, m_err;
    logic [3:0]  m_da, m_db;
    logic [15:0] m_drop;
    logic [3:0]  m_drop4;

    function automatic logic [3:0] count_valid(input logic [87:0] a);
        logic [3:0] n = '0;
        for (int i = 0; i < 8; i++)
            if (a[i*11 +: 11] != 11'h7FF) n = n + 4'd1;
        return n;
    endfunction

    // Predict one clock, advance, then compare handshake state and any new frame.
    task automatic tick();
        exp_t e;
        logic cap, free, edge_valid, edge_ready;
        cap  = (m_phase[1:0] == cfg_capture_phase);
        free = !m_valid || out_ready;
        if (cap && free) begin
            e.adr = sorter_adr; e.cnt = sorter_cnt;
            e.src = m_phase[2]; e.ncl = count_valid(sorter_adr);
            sb.push_back(e);
            m_valid = 1'b1;
        end else if (cap) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            if (m_drop4 != 4'hF) m_drop4 = m_drop4 + 4'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (bx0 && m_phase != 3'd0) m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
        if (m_phase == 3'd0) begin m_da = cfg_delay_a; m_db = cfg_delay_b; end
        m_phase = bx0 ? 3'd1 : m_phase + 3'd1;
        edge_valid = out_valid;
        edge_ready = out_ready;

        @(posedge clock4x); #1;

        checks++;
        if (out_valid !== m_valid) begin
            errors++; $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
        end
        checks++;
        if (cycle !== m_phase[2]) begin
            errors++; $display("FAIL cycle: got %b expected %b", cycle, m_phase[2]);
        end
        checks++;
        if (phase_err !== m_err) begin
            errors++; $display("FAIL phase_err: got %b expected %b", phase_err, m_err);
        end
        checks++;
        if (drop_cnt !== m_drop || drop_cnt4 !== m_drop4) begin
            errors++;
            $display("FAIL drop_cnt: got %0d/%0d expected %0d/%0d", drop_cnt, drop_cnt4, m_drop, m_drop4);
        end
        checks++;
        if (delay_a !== m_da || delay_b !== m_db) begin
            errors++;
            $display("FAIL delays: got %0d/%0d expected %0d/%0d", delay_a, delay_b, m_da, m_db);
        end
        if (out_valid === 1'b1 && (!edge_valid || edge_ready)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL frame: got unexpected frame, expected none");
            end else begin
                e = sb.pop_front();
                if ({out_adr, out_cnt, out_src, out_nclusters} !== {e.adr, e.cnt, e.src, e.ncl}) begin
                    errors++;
                    $display("FAIL frame: got adr=%h cnt=%h src=%b n=%0d expected adr=%h cnt=%h src=%b n=%0d",
                             out_adr, out_cnt, out_src, out_nclusters, e.adr, e.cnt, e.src, e.ncl);
                end
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clock4x); #1;
        global_reset = 1'b0;
        m_phase = 3'd1; m_valid = 1'b0; m_err = 1'b0;
        m_da = 4'd7; m_db = 4'd3; m_drop = '0; m_drop4 = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        #2;
        checks++;
        if (delay_a !== 4'd7 || delay_b !== 4'd3) begin
            errors++; $display("FAIL reset_delays: got %0d/%0d expected 7/3", delay_a, delay_b);
        end
        checks++;
        if (out_valid !== 1'b0 || out_src !== 1'b0 || out_nclusters !== 4'd0 || out_cnt !== 24'd0) begin
            errors++;
            $display("FAIL reset_frame: got v=%b s=%b n=%0d c=%h expected 0 0 0 0",
                     out_valid, out_src, out_nclusters, out_cnt);
        end
        checks++;
        if (out_adr !== {8{11'h7FF}}) begin
            errors++; $display("FAIL reset_adr: got %h expected all 7ff", out_adr);
        end
        checks++;
        if (phase_err !== 1'b0 || drop_cnt !== 16'd0 || drop_cnt4 !== 4'd0 || cycle !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got err=%b drop=%0d drop4=%0d cycle=%b expected 0 0 0 0",
                     phase_err, drop_cnt, drop_cnt4, cycle);
        end
        release_reset();
    endtask

    task automatic test_free_running();
        int   pulses = 0;
        logic last_src = 1'b1;
        cfg_capture_phase = 2'd2;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sorter_adr = {$urandom, $urandom, $urandom};
            sorter_cnt = 24'($urandom);
            tick();
            if (out_valid === 1'b1) begin
                pulses++;
                checks++;
                if (out_src === last_src) begin
                    errors++; $display("FAIL src_alternate: got %b expected %b", out_src, !last_src);
                end
                last_src = out_src;
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL pulse_count: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_phase_err();
        int n = 0;
        for (int i = 0; i < 8 && m_phase != 3'd0; i++) tick();
        bx0 = 1'b1; tick(); bx0 = 1'b0;
        checks++;
        if (phase_err !== 1'b0) begin
            errors++; $display("FAIL bx0_aligned: got %b expected 0", phase_err);
        end
        for (int i = 0; i < 8 && m_phase != 3'd5; i++) tick();
        bx0 = 1'b1; tick(); bx0 = 1'b0;
        checks++;
        if (phase_err !== 1'b1) begin
            errors++; $display("FAIL bx0_misaligned: got %b expected 1", phase_err);
        end
        for (int i = 0; i < 8 && cycle !== 1'b1; i++) begin tick(); n++; end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL bx0_phase_load: got %0d cycles to cycle=1 expected 3", n);
        end
        bx0 = 1'b1; err_clear = 1'b1; tick(); bx0 = 1'b0;
        checks++;
        if (phase_err !== 1'b1) begin
            errors++; $display("FAIL set_wins: got %b expected 1", phase_err);
        end
        tick(); err_clear = 1'b0;
        checks++;
        if (phase_err !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", phase_err);
        end
    endtask

    task automatic test_delay_update();
        logic was_zero;
        for (int i = 0; i < 8 && m_phase != 3'd3; i++) tick();
        cfg_delay_a = 4'd5;
        for (int i = 0; i < 8; i++) begin
            was_zero = (m_phase == 3'd0);
            tick();
            checks++;
            if (delay_a !== (was_zero ? 4'd5 : 4'd7)) begin
                errors++;
                $display("FAIL delay_a_update: got %0d expected %0d", delay_a, was_zero ? 5 : 7);
            end
            if (was_zero) break;
        end
        cfg_delay_a = 4'd7;
    endtask

    task automatic test_nclusters();
        logic [87:0] pats[3];
        logic [3:0]  want[3];
        logic        seen;
        pats[0] = {{5{11'h7FF}}, 11'h6AB, 11'h345, 11'h012}; want[0] = 4'd3;
        pats[1] = {11'h000, 11'h111, 11'h222, 11'h333, 11'h444, 11'h555, 11'h666, 11'h7FE}; want[1] = 4'd8;
        pats[2] = {8{11'h7FF}}; want[2] = 4'd0;
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            sorter_adr = pats[p];
            sorter_cnt = 24'($urandom);
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                tick();
                seen = (out_valid === 1'b1);
            end
            checks++;
            if (!seen || out_nclusters !== want[p] || out_adr !== pats[p]) begin
                errors++;
                $display("FAIL nclusters_%0d: got n=%0d adr=%h expected n=%0d adr=%h",
                         p, out_nclusters, out_adr, want[p], pats[p]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [87:0] first_adr = '0;
        int caps = 0;
        logic cap_now;
        global_reset = 1'b1; #2; release_reset();
        cfg_capture_phase = 2'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 40 && caps < 3; i++) begin
            sorter_adr = {$urandom, $urandom, $urandom};
            cap_now = (m_phase[1:0] == cfg_capture_phase);
            if (cap_now && caps == 0) first_adr = sorter_adr;
            tick();
            if (cap_now) caps++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_adr !== first_adr || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL backpressure_hold: got v=%b adr=%h drop=%0d expected 1 %h 2",
                     out_valid, out_adr, drop_cnt, first_adr);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        global_reset = 1'b1; #2; release_reset();
        cfg_capture_phase = 2'd2;
        out_ready = 1'b0;
        repeat (80) begin
            sorter_adr = {$urandom, $urandom, $urandom};
            tick();
        end
        checks++;
        if (drop_cnt4 !== 4'd15 || drop_cnt !== 16'd19) begin
            errors++;
            $display("FAIL drop_saturate: got %0d/%0d expected 15/19", drop_cnt4, drop_cnt);
        end
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        sorter_adr = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 8 && out_valid !== 1'b1; i++) tick();
        global_reset = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_adr !== {8{11'h7FF}}) begin
            errors++; $display("FAIL midframe_reset: got v=%b adr=%h expected 0 all 7ff", out_valid, out_adr);
        end
        release_reset();
        out_ready = 1'b1;
        cfg_capture_phase = 2'd2;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL first_capture_early: got %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 1'b0) begin
            errors++; $display("FAIL first_capture: got v=%b src=%b expected 1 0", out_valid, out_src);
        end
        repeat (6) tick();
    endtask

    initial begin
        global_reset      = 1'b1;
        bx0               = 1'b0;
        err_clear         = 1'b0;
        cfg_delay_a       = 4'd7;
        cfg_delay_b       = 4'd3;
        cfg_capture_phase = 2'd2;
        out_ready         = 1'b1;
        sorter_adr        = {8{11'h7FF}};
        sorter_cnt        = '0;
        @(posedge clock4x); #1;

        test_reset();
        test_free_running();
        test_phase_err();
        test_delay_update();
        test_nclusters();
        test_backpressure();
        test_saturation();
        test_reset_midframe();

        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending frames expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
